// File: rtl/fetch_pkg.sv
// Shared defaults and the decode-queue entry layout for the fetch queue stage.
package fetch_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned ILEN_DEF     = 32;
  localparam int unsigned DEPTH_DEF    = 4;
  localparam int unsigned INCR_DEF     = 4;
  localparam int unsigned RESET_PC_DEF = 0;

  localparam logic [XLEN_DEF-1:0] ZERO_PC    = '0;
  localparam logic [ILEN_DEF-1:0] ZERO_INSTR = '0;

  // One queue slot as seen by decode, at the default widths.
  typedef struct packed {
    logic [ILEN_DEF-1:0] instr;
    logic [XLEN_DEF-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_stage_if.sv
// Redirect, instruction-memory and decode channels of the fetch queue stage.
interface fetch_queue_stage_if
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned ILEN  = ILEN_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] redirect_disp;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;

  logic            dec_valid;
  logic            dec_ready;
  logic [ILEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [CW-1:0]   occupancy;

  // Fetch stage side.
  modport master (
    input  redirect, redirect_pc, redirect_disp,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output dec_valid,
    input  dec_ready,
    output dec_instr, dec_pc, occupancy
  );

  // Environment side: EX, instruction memory and decode.
  modport slave (
    output redirect, redirect_pc, redirect_disp,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  dec_valid,
    output dec_ready,
    input  dec_instr, dec_pc, occupancy
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO; flush empties it and wins over push/pop in the same cycle.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointer and count update; DEPTH is a power of two so pointers wrap freely.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; slot contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, queues
// in-order responses for decode, and drops responses made stale by redirects.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int unsigned    XLEN     = XLEN_DEF,
  parameter int unsigned    ILEN     = ILEN_DEF,
  parameter int unsigned    DEPTH    = DEPTH_DEF,
  parameter logic [XLEN-1:0] INCR     = XLEN'(INCR_DEF),
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input logic                 clk,
  input logic                 rst,
  fetch_queue_stage_if.master bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned KW = CW + 1;
  localparam int unsigned EW = ILEN + XLEN;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [KW-1:0]   live_q, live_d;
  logic [KW-1:0]   drop_q, drop_d;

  logic [XLEN-1:0] target;
  logic [KW:0]     credit_sum;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   fifo_head;
  entry_t          wr_entry;
  entry_t          head_entry;

  assign target = bus.redirect_pc + bus.redirect_disp;

  // Credit: queued entries plus live in-flight requests never exceed DEPTH.
  assign credit_sum         = (KW+1)'(fifo_count) + (KW+1)'(live_q);
  assign bus.imem_req_valid = !rst && (credit_sum < (KW+1)'(DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // A response is pushed only when nothing stale is still owed and no redirect is underway.
  assign push = bus.imem_rsp_valid && !bus.redirect && (drop_q == '0) && (!fifo_full || pop);

  assign bus.dec_valid = !fifo_empty && !bus.redirect;
  assign pop           = bus.dec_valid && bus.dec_ready;

  assign wr_entry   = '{instr: bus.imem_rsp_data, pc: rsp_pc_q};
  assign head_entry = entry_t'(fifo_head);

  assign bus.dec_instr = fifo_empty ? '0 : head_entry.instr;
  assign bus.dec_pc    = fifo_empty ? '0 : head_entry.pc;
  assign bus.occupancy = fifo_count;

  // Next-state for PC tracking and the live/stale request counters.
  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    live_d   = live_q;
    drop_d   = drop_q;
    if (bus.redirect) begin
      // Everything outstanding, including a request leaving now, becomes stale;
      // a response arriving now retires one of those.
      pc_d     = target;
      rsp_pc_d = target;
      live_d   = '0;
      drop_d   = drop_q + live_q + KW'(req_fire) - KW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + INCR;
      if (push) rsp_pc_d = rsp_pc_q + INCR;
      if (bus.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - KW'(1);
      live_d = live_q + KW'(req_fire) - KW'(push);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      live_q   <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      live_q   <= live_d;
      drop_q   <= drop_d;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata (EW'(wr_entry)),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: in-order random-latency memory, request-tagged
// reference queue, directed scenarios followed by a randomized soak.
module tb_fetch_queue_stage;
  import fetch_pkg::*;

  localparam int unsigned XL = 32;
  localparam int unsigned IL = 32;
  localparam int unsigned DP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_stage_if #(.XLEN(XL), .ILEN(IL), .DEPTH(DP)) bus ();

  fetch_queue_stage #(.XLEN(XL), .ILEN(IL), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } preq_t;

  preq_t        pend[$];
  fetch_entry_t mq[$];
  logic [31:0]  pop_log[$];
  logic [31:0]  acc_log[$];

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int epoch = 0;
  int last_due = 0;
  int rst_cyc = 0;
  int first_dv = -1;
  bit chk_en = 0;
  logic [31:0] m_pc = '0;

  int rdy_pct = 100, drdy_pct = 100, lat_min = 1, lat_max = 1;
  bit rst_req = 0, redir_req = 0;
  logic [31:0] rpc = '0, rdisp = '0;

  function automatic logic [31:0] img(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  // One clock: drive inputs at negedge, compare against the model, advance the model.
  task automatic step();
    bit rsp, redir, do_rst, exp_rv, pop_m, acc_m;
    int live, lat, due;
    preq_t r;
    @(negedge clk);
    do_rst  = rst_req;   rst_req   = 0;
    redir   = redir_req; redir_req = 0;
    rst               = do_rst;
    bus.redirect      = redir;
    bus.redirect_pc   = redir ? rpc   : 32'($urandom);
    bus.redirect_disp = redir ? rdisp : 32'($urandom);
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    bus.dec_ready      = ($urandom_range(99) < drdy_pct);
    rsp = (pend.size() > 0) && (pend[0].due <= ncyc);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? img(pend[0].addr) : 32'($urandom);
    #1;
    live = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) live++;
    exp_rv = !do_rst && ((mq.size() + live) < DP);
    pop_m  = !do_rst && (mq.size() > 0) && !redir && bus.dec_ready;
    acc_m  = exp_rv && bus.imem_req_ready;
    if (chk_en) begin
      chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
      if (exp_rv) chk("req_addr", 64'(bus.imem_req_addr), 64'(m_pc));
      chk("dec_valid", 64'(bus.dec_valid), 64'((mq.size() > 0) && !redir));
      chk("dec_pc", 64'(bus.dec_pc), 64'(mq.size() > 0 ? mq[0].pc : 32'h0));
      chk("dec_instr", 64'(bus.dec_instr), 64'(mq.size() > 0 ? mq[0].instr : 32'h0));
      chk("occupancy", 64'(bus.occupancy), 64'(mq.size()));
      if (bus.dec_valid && first_dv < 0 && !do_rst) first_dv = ncyc;
    end
    if (do_rst) begin
      mq.delete();
      pend.delete();
      m_pc = 32'(RESET_PC_DEF);
      epoch++;
      rst_cyc  = ncyc;
      first_dv = -1;
    end else begin
      if (pop_m) begin
        pop_log.push_back(mq[0].pc);
        void'(mq.pop_front());
      end
      if (rsp) begin
        r = pend.pop_front();
        if (!redir && r.epoch == epoch) mq.push_back('{instr: img(r.addr), pc: r.addr});
      end
      if (acc_m) begin
        lat = $urandom_range(lat_max, lat_min);
        due = ncyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{addr: m_pc, epoch: epoch, due: due});
        acc_log.push_back(m_pc);
        m_pc = m_pc + 32'(INCR_DEF);
      end
      if (redir) begin
        mq.delete();
        epoch++;
        m_pc = rpc + rdisp;
      end
    end
    ncyc++;
  endtask

  task automatic do_reset();
    rst_req = 1;
    step();
    acc_log.delete();
    pop_log.delete();
  endtask

  task automatic redirect_to(input logic [31:0] p, input logic [31:0] d);
    rpc = p; rdisp = d; redir_req = 1;
    pop_log.delete();
    step();
  endtask

  // Run until n entries have been popped by decode, bounded by a cycle budget.
  task automatic run_pops(input int n, input int limit, input string nm);
    int k = 0;
    while (pop_log.size() < n && k < limit) begin
      step();
      k++;
    end
    chk({nm, "_timeout"}, 64'(pop_log.size() >= n), 64'(1));
  endtask

  initial begin
    bus.redirect = 0; bus.redirect_pc = '0; bus.redirect_disp = '0;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
    bus.dec_ready = 0;

    // Initial reset; DUT state is unknown before the first reset edge.
    do_reset();
    chk_en = 1;

    // Latency-1 memory streaming straight through to decode.
    do_reset();
    run_pops(4, 40, "stream");
    chk("first_dv_latency", 64'(first_dv - rst_cyc), 64'(3));
    if (pop_log.size() >= 4) begin
      chk("stream_pc0", 64'(pop_log[0]), 64'h0);
      chk("stream_pc1", 64'(pop_log[1]), 64'h4);
      chk("stream_pc2", 64'(pop_log[2]), 64'h8);
      chk("stream_pc3", 64'(pop_log[3]), 64'hC);
    end

    // Decode stalled: credit stops fetching at DEPTH.
    drdy_pct = 0;
    do_reset();
    repeat (20) step();
    chk("stall_acc_count", 64'(acc_log.size()), 64'(4));
    if (acc_log.size() >= 4) chk("stall_last_addr", 64'(acc_log[3]), 64'hC);
    chk("stall_occupancy", 64'(bus.occupancy), 64'(4));
    chk("stall_req_valid", 64'(bus.imem_req_valid), 64'(0));
    drdy_pct = 100;
    begin
      int k = 0;
      while (acc_log.size() < 5 && k < 20) begin step(); k++; end
    end
    chk("resume_addr", 64'(acc_log.size() >= 5 ? acc_log[4] : 32'hDEAD), 64'h10);

    // Latency-3 memory, redirect with two requests outstanding.
    lat_min = 3; lat_max = 3;
    do_reset();
    step(); step();
    chk("inflight_before_redirect", 64'(pend.size()), 64'(2));
    redirect_to(32'h100, 32'h20);
    run_pops(2, 40, "redir_lat3");
    if (pop_log.size() >= 2) begin
      chk("redir_pc0", 64'(pop_log[0]), 64'h120);
      chk("redir_pc1", 64'(pop_log[1]), 64'h124);
    end

    // Redirect colliding with a response and a decode pop.
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (8) step();
    redirect_to(32'h1F0, 32'h10);
    chk("redir_dv_forced", 64'(bus.dec_valid), 64'(0));
    step();
    chk("redir_occ_zero", 64'(bus.occupancy), 64'(0));
    run_pops(1, 40, "collide");
    if (pop_log.size() >= 1) chk("collide_pc0", 64'(pop_log[0]), 64'h200);

    // Target and sequential PC wrap-around.
    redirect_to(32'hFFFF_FFF0, 32'h20);
    run_pops(1, 40, "wrap_tgt");
    if (pop_log.size() >= 1) chk("wrap_tgt_pc", 64'(pop_log[0]), 64'h10);
    redirect_to(32'hFFFF_FFF0, 32'h8);
    run_pops(3, 40, "wrap_inc");
    if (pop_log.size() >= 3) begin
      chk("wrap_pc0", 64'(pop_log[0]), 64'hFFFF_FFF8);
      chk("wrap_pc1", 64'(pop_log[1]), 64'hFFFF_FFFC);
      chk("wrap_pc2", 64'(pop_log[2]), 64'h0);
    end

    // Reset together with a redirect mid-stream.
    lat_min = 1; lat_max = 4; rdy_pct = 80;
    repeat (10) step();
    rst_req = 1; rpc = 32'h4000; rdisp = 32'h40; redir_req = 1;
    step();
    chk("rst_req_valid_low", 64'(bus.imem_req_valid), 64'(0));
    rdy_pct = 0;
    step();
    chk("rst_occ", 64'(bus.occupancy), 64'(0));
    chk("rst_dec_valid", 64'(bus.dec_valid), 64'(0));
    chk("rst_dec_pc", 64'(bus.dec_pc), 64'(0));
    chk("rst_dec_instr", 64'(bus.dec_instr), 64'(0));
    chk("rst_req_addr", 64'(bus.imem_req_addr), 64'(RESET_PC_DEF));

    // Randomized soak with redirects, resets and varying latency/backpressure.
    lat_min = 1; lat_max = 5;
    for (int i = 0; i < 4000; i++) begin
      rdy_pct  = 40 + int'($urandom_range(60));
      drdy_pct = 30 + int'($urandom_range(70));
      if ($urandom_range(99) < 4) begin
        rpc = 32'($urandom); rdisp = 32'($urandom); redir_req = 1;
      end
      if ($urandom_range(999) < 5) rst_req = 1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised successor to the single-register fetch stage. Owns the PC and issues fetch requests to instruction memory over a valid/ready request channel. Accepts in-order responses into a DEPTH-entry instruction queue and presents {instr, pc} to decode over a valid/ready handshake. EX-stage redirects (base + displacement) flush the queue and discard stale in-flight responses.

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction width
DEPTH, 4, queue entries (power of 2, >=2)
INCR, 4, sequential PC increment
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
redirect  in  1  EX redirect strobe, single cycle
redirect_pc  in  XLEN  redirect base PC
redirect_disp  in  XLEN  redirect displacement
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  XLEN  fetch address (= PC)
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  response valid; responses return in request order, any latency >=1
imem_rsp_data  in  ILEN  fetched instruction
dec_valid  out  1  queue head valid
dec_ready  in  1  decode accepts head
dec_instr  out  ILEN  head instruction, 0 when empty
dec_pc  out  XLEN  head PC, 0 when empty
occupancy  out  $clog2(DEPTH+1)  entries in queue

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, rsp_pc=RESET_PC, queue empty, inflight=0, drop=0. Outputs next cycle: imem_req_valid=0 in the reset cycle only, dec_valid=0, dec_instr=0, dec_pc=0, occupancy=0. rst overrides redirect and all handshakes in the same cycle.
- Credit rule: imem_req_valid = !rst && (occupancy + inflight_live < DEPTH). inflight_live counts accepted, non-stale, unreturned requests. A response therefore always has a free slot; overflow is impossible.
- Request accept (valid&ready): pc <= pc+INCR (mod 2^XLEN), inflight_live++.
- Response, drop==0: push {imem_rsp_data, rsp_pc}; rsp_pc <= rsp_pc+INCR; inflight_live--. Response is visible on dec_* the next cycle; no combinational bypass.
- Response, drop>0: discarded; drop--.
- Pop: dec_valid&dec_ready pops head. Simultaneous push and pop keeps occupancy unchanged. Pop on empty is impossible because dec_valid=0.
- Redirect:
  - target = redirect_pc + redirect_disp, truncated to XLEN.
  - Next cycle: pc=target, rsp_pc=target, queue empty.
  - drop = drop + inflight_live + (request accepted this cycle) - (stale response this cycle).
  - inflight_live = 0.
  - A response arriving in the redirect cycle is treated as stale: not pushed; it consumes drop or inflight accordingly.
  - A pop in the redirect cycle is squashed; dec_valid is forced 0 during the redirect cycle.
  - First request to target is issued the cycle after redirect, subject to credit (drop entries do not consume credit).
- Back-to-back redirects: each one retargets; drop accumulates correctly.
- Request protocol: once imem_req_valid is asserted, it and imem_req_addr hold until accepted, except on a redirect or reset edge.
- Counters: inflight_live and drop are $clog2(DEPTH+1)+1 bits wide. drop never underflows.

Decomposition:
- fetch_pkg: XLEN/ILEN defaults, INCR, RESET_PC, zero constants, and the queue-entry struct {instr, pc}.
- Sub-module fetch_fifo: sync FIFO with parameters WIDTH and DEPTH; ports push, pop, flush, full, empty, count, head. flush has priority over push/pop. The top level instantiates it with WIDTH=ILEN+XLEN.

Test Plan:
- Reset, then memory with fixed 1-cycle latency, dec_ready=1 -> dec_pc sequence 0,4,8,12, instr matches memory image; first dec_valid appears 3 cycles after rst deassert.
- dec_ready=0, DEPTH=4 -> exactly 4 requests issued (addrs 0..12), then imem_req_valid=0; occupancy=4. Release dec_ready -> fetching resumes at 16.
- Latency-3 memory, redirect with pc=0x100, disp=0x20 while 2 requests are in flight -> the 2 responses are dropped; next dec_pc=0x120, then 0x124.
- Redirect coinciding with a response and a dec pop -> no push; pop squashed; occupancy=0 next cycle; drop accounting leaves no stale instruction reaching decode.
- Redirect pc=0xFFFFFFF0, disp=0x20 -> target 0x10 (wraps). PC increments at 0xFFFFFFFC wrap to 0.
- rst asserted mid-stream with a redirect in the same cycle -> pc=RESET_PC, all outputs zero, and in-flight responses after reset are accepted as new ones only per the bench's memory reset.
